// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encodings match the values used elsewhere in uart_axi_lite_top.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        UTA_IDLE   = 2'd0,
        UTA_LAUNCH = 2'd1,
        UTA_SEND   = 2'd2
    } uta_state_e;

    localparam logic [15:0] UART_DEFAULT_DIV = 16'd54;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Bits needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i,
// wrapping around.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDW-1:0]     index_o,
    output logic               any_o
);

    always_comb begin
        int j;
        j        = 0;
        onehot_o = '0;
        index_o  = '0;
        any_o    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && eligible_i[j]) begin
                any_o       = 1'b1;
                onehot_o[j] = 1'b1;
                index_o     = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte streams, with
// optional packet locking and a burst cap on locked grants.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  LOCK_ON_PACKET = 1,
    parameter int  MAX_BURST      = 16,
    localparam int IDW            = cnt_width(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 grant_active_o,
    output logic                 byte_done_o
);

    localparam int BCW = cnt_width(MAX_BURST + 1);

    uta_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic           lock_q, lock_d;
    logic           last_q, last_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;

    logic [NUM_REQ-1:0] grant_mask;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [7:0]         pick_byte;
    logic               pick_last;
    logic               burst_hit;
    logic               rel_grant;
    logic [IDW-1:0]     next_ptr;

    // While locked only the holder may win; the picker then finds it from any ptr.
    always_comb begin
        grant_mask             = '0;
        grant_mask[grant_id_q] = 1'b1;
    end

    assign eligible = lock_q ? (req_valid_i & grant_mask) : req_valid_i;

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .onehot_o   (pick_onehot),
        .index_o    (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        pick_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_byte = req_data_i[8*i +: 8];
                pick_last = req_last_i[i];
            end
        end
    end

    assign burst_hit = (MAX_BURST != 0) && ((int'(burst_cnt_q) + 1) == MAX_BURST);
    assign rel_grant = (LOCK_ON_PACKET == 0) || last_q || burst_hit;
    assign next_ptr  = IDW'((int'(grant_id_q) + 1) % NUM_REQ);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        lock_d      = lock_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        tx_data_d   = tx_data_q;
        req_ready_o = '0;
        tx_start_o  = 1'b0;
        byte_done_o = 1'b0;
        unique case (state_q)
            UTA_IDLE: begin
                req_ready_o = pick_onehot;
                if (pick_any) begin
                    tx_data_d  = pick_byte;
                    grant_id_d = pick_idx;
                    last_d     = pick_last;
                    state_d    = UTA_LAUNCH;
                end
            end
            UTA_LAUNCH: begin
                // A busy flag left over from the previous frame also counts as the ack.
                tx_start_o = 1'b1;
                if (tx_busy_i) begin
                    state_d = UTA_SEND;
                end
            end
            UTA_SEND: begin
                if (!tx_busy_i) begin
                    byte_done_o = 1'b1;
                    state_d     = UTA_IDLE;
                    if (rel_grant) begin
                        lock_d      = 1'b0;
                        burst_cnt_d = '0;
                        rr_ptr_d    = next_ptr;
                    end else begin
                        lock_d      = 1'b1;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = UTA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= UTA_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
            burst_cnt_q <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_data_o      = tx_data_q;
    assign grant_id_o     = grant_id_q;
    assign grant_active_o = (state_q != UTA_IDLE) | lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (burst cap 16 and 2) with a uart_tx busy model
// that acks two cycles after tx_start and stays busy for four cycles.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   a_valid, a_last, a_ready, a_hold;
    logic [8*N-1:0] a_data;
    logic [7:0]     a_txd;
    logic [1:0]     a_gid;
    logic           a_start, a_busy, a_gact, a_done;

    logic [N-1:0]   b_valid, b_last, b_ready;
    logic [8*N-1:0] b_data;
    logic [7:0]     b_txd;
    logic [1:0]     b_gid;
    logic           b_start, b_busy, b_gact, b_done;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_ON_PACKET(1), .MAX_BURST(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_valid), .req_data_i(a_data),
        .req_last_i(a_last), .req_ready_o(a_ready), .tx_data_o(a_txd), .tx_start_o(a_start),
        .tx_busy_i(a_busy), .grant_id_o(a_gid), .grant_active_o(a_gact), .byte_done_o(a_done));

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_ON_PACKET(1), .MAX_BURST(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_valid), .req_data_i(b_data),
        .req_last_i(b_last), .req_ready_o(b_ready), .tx_data_o(b_txd), .tx_start_o(b_start),
        .tx_busy_i(b_busy), .grant_id_o(b_gid), .grant_active_o(b_gact), .byte_done_o(b_done));

    // uart_tx stand-ins
    int a_dly, a_bcnt, b_dly, b_bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_busy <= 1'b0; a_dly <= 0; a_bcnt <= 0;
        end else if (a_bcnt > 0) begin
            a_bcnt <= a_bcnt - 1;
            if (a_bcnt == 1) a_busy <= 1'b0;
        end else if (a_start && !a_busy) begin
            if (a_dly == 1) begin a_busy <= 1'b1; a_bcnt <= 4; a_dly <= 0; end
            else a_dly <= a_dly + 1;
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_busy <= 1'b0; b_dly <= 0; b_bcnt <= 0;
        end else if (b_bcnt > 0) begin
            b_bcnt <= b_bcnt - 1;
            if (b_bcnt == 1) b_busy <= 1'b0;
        end else if (b_start && !b_busy) begin
            if (b_dly == 1) begin b_busy <= 1'b1; b_bcnt <= 4; b_dly <= 0; end
            else b_dly <= b_dly + 1;
        end
    end

    // Requester byte queues {last, data} and accepted-byte logs (id*256 + data)
    logic [8:0] aq [N][$];
    logic [8:0] bq [N][$];
    int a_log[$];
    int b_log[$];

    int checks = 0, errors = 0;
    int cyc = 0, rdy_cyc = 0, start_cyc = 0, done_cnt = 0, viol = 0, txd_bad = 0, gact_low = 0;
    int rdy_cnt [N];
    logic [7:0] last_byte = 8'h00;
    logic a_start_prev = 1'b0;
    logic watch = 1'b0;
    logic [N-1:0] a_hs, b_hs;

    initial begin
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        a_valid = '0; a_last = '0; a_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            a_hs = a_ready & a_valid;
            if ($countones(a_ready) > 1 || (a_ready != '0 && a_start)) viol++;
            for (int i = 0; i < N; i++) begin
                if (a_hs[i]) begin
                    a_log.push_back(i*256 + int'(a_data[8*i +: 8]));
                    last_byte = a_data[8*i +: 8];
                    rdy_cnt[i]++;
                    rdy_cyc = cyc;
                end
            end
            if (a_done) done_cnt++;
            if (a_start && !a_start_prev) start_cyc = cyc;
            if (a_start && a_txd != last_byte) txd_bad++;
            if (watch && !a_gact) gact_low++;
            a_start_prev = a_start;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (a_hs[i]) void'(aq[i].pop_front());
                a_valid[i]       = (aq[i].size() > 0) && !a_hold[i];
                a_data[8*i +: 8] = (aq[i].size() > 0) ? aq[i][0][7:0] : 8'h00;
                a_last[i]        = (aq[i].size() > 0) ? aq[i][0][8] : 1'b0;
            end
        end
    end

    initial begin
        b_valid = '0; b_last = '0; b_data = '0;
        forever begin
            @(negedge clk);
            b_hs = b_ready & b_valid;
            if ($countones(b_ready) > 1) viol++;
            for (int i = 0; i < N; i++)
                if (b_hs[i]) b_log.push_back(i*256 + int'(b_data[8*i +: 8]));
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (b_hs[i]) void'(bq[i].pop_front());
                b_valid[i]       = bq[i].size() > 0;
                b_data[8*i +: 8] = (bq[i].size() > 0) ? bq[i][0][7:0] : 8'h00;
                b_last[i]        = (bq[i].size() > 0) ? bq[i][0][8] : 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_a(input int n, input string tag);
        int t = 0;
        while (a_log.size() < n && t < 400) begin @(negedge clk); t++; end
        if (a_log.size() < n) chk({tag, "_timeout"}, a_log.size(), n);
    endtask

    task automatic wait_b(input int n, input string tag);
        int t = 0;
        while (b_log.size() < n && t < 400) begin @(negedge clk); t++; end
        if (b_log.size() < n) chk({tag, "_timeout"}, b_log.size(), n);
    endtask

    task automatic wait_idle_a(input string tag);
        int t = 0;
        while ((a_gact || a_busy || a_start) && t < 200) begin @(negedge clk); t++; end
        if (a_gact || a_busy || a_start) chk({tag, "_idle"}, {a_gact, a_busy, a_start}, 0);
    endtask

    initial begin
        int base, n0, t;
        rst_n  = 1'b0;
        a_hold = '0;
        cycles(3);
        chk("rst_ready", a_ready, 0);
        chk("rst_start", a_start, 0);
        chk("rst_txd", a_txd, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_gact", a_gact, 0);
        chk("rst_done", a_done, 0);
        rst_n = 1'b1;
        cycles(2);

        // single uncontended byte
        aq[0].push_back({1'b1, 8'hA5});
        wait_a(1, "t1");
        wait_idle_a("t1");
        chk("t1_grant", a_log[0], 32'h0A5);
        chk("t1_ready_cycles", rdy_cnt[0], 1);
        chk("t1_byte_done", done_cnt, 1);
        chk("t1_latency", start_cyc - rdy_cyc, 1);
        chk("t1_txd_hold", txd_bad, 0);
        chk("t1_rr_ptr", dut_a.rr_ptr_q, 1);

        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // all four contending
        base = a_log.size();
        for (int i = 0; i < N; i++) aq[i].push_back({1'b1, 8'(8'h10 + i)});
        aq[0].push_back({1'b1, 8'h14});
        wait_a(base + 5, "t2");
        for (int k = 0; k < 4; k++) chk("t2_order", a_log[base + k], k*256 + 16 + k);
        chk("t2_order_wrap", a_log[base + 4], 32'h014);
        chk("t2_one_ready", viol, 0);
        wait_idle_a("t2");

        // locked 3-byte packet from req1 vs req2
        base = a_log.size();
        aq[1].push_back({1'b0, 8'h31});
        aq[1].push_back({1'b0, 8'h32});
        aq[1].push_back({1'b1, 8'h33});
        aq[2].push_back({1'b1, 8'h40});
        wait_a(base + 1, "t3");
        @(posedge clk);
        gact_low = 0;
        watch    = 1'b1;
        wait_a(base + 3, "t3");
        watch = 1'b0;
        wait_a(base + 4, "t3");
        chk("t3_b0", a_log[base], 32'h131);
        chk("t3_b1", a_log[base + 1], 32'h132);
        chk("t3_b2", a_log[base + 2], 32'h133);
        chk("t3_req2", a_log[base + 3], 32'h240);
        chk("t3_gact_held", gact_low, 0);
        wait_idle_a("t3");

        // burst cap of 2 on the second arbiter
        for (int k = 0; k < 5; k++) bq[0].push_back({1'b0, 8'(8'h50 + k)});
        bq[3].push_back({1'b1, 8'h60});
        wait_b(6, "t4");
        chk("t4_0", b_log[0], 32'h050);
        chk("t4_1", b_log[1], 32'h051);
        chk("t4_2", b_log[2], 32'h360);
        chk("t4_3", b_log[3], 32'h052);
        chk("t4_4", b_log[4], 32'h053);
        chk("t4_5", b_log[5], 32'h054);
        chk("t4_one_ready", viol, 0);

        // locked requester stalls
        base = a_log.size();
        aq[2].push_back({1'b0, 8'h70});
        wait_a(base + 1, "t5");
        a_hold[2] = 1'b1;
        aq[2].push_back({1'b1, 8'h71});
        aq[0].push_back({1'b1, 8'h80});
        cycles(12);
        n0 = a_log.size();
        chk("t5_first", n0, base + 1);
        cycles(10);
        chk("t5_no_grant", a_log.size(), n0);
        chk("t5_ready_low", a_ready, 0);
        chk("t5_idle_locked", {a_gact, a_start}, 2'b10);
        a_hold[2] = 1'b0;
        wait_a(base + 3, "t5");
        chk("t5_resume", a_log[base + 1], 32'h271);
        chk("t5_then_req0", a_log[base + 2], 32'h080);
        wait_idle_a("t5");

        // reset while in SEND
        aq[1].push_back({1'b1, 8'h90});
        t = 0;
        while (!a_busy && t < 100) begin @(negedge clk); t++; end
        cycles(2);
        chk("t6_in_send", dut_a.state_q, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_start", a_start, 0);
        chk("t6_txd", a_txd, 0);
        chk("t6_gid", a_gid, 0);
        chk("t6_gact", a_gact, 0);
        chk("t6_done", a_done, 0);
        chk("t6_ready", a_ready, 0);
        cycles(2);
        rst_n = 1'b1;
        base = a_log.size();
        aq[2].push_back({1'b1, 8'hA2});
        aq[0].push_back({1'b1, 8'hA0});
        wait_a(base + 2, "t6");
        chk("t6_first", a_log[base], 32'h0A0);
        chk("t6_second", a_log[base + 1], 32'h2A2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

endmodule
